// File: rtl/frame_energy_pkg.sv
// Shared types and helpers for the frame energy accumulator.
// Optional feature macro: FRAME_ENERGY_SUM_EN (signed frame sum output).
package frame_energy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fe_state_e;

    // Energy accumulator width: DEPTH squares of WIDTH-bit magnitudes never overflow.
    function automatic int acc_width(input int width, input int depth);
        return 2 * width + $clog2(depth);
    endfunction

endpackage

// File: rtl/frame_energy_acc_if.sv
// Stream bundle between the frame energy accumulator and its neighbours.
// Optional feature macro: FRAME_ENERGY_SUM_EN adds result_sum.
//
// Handshake: a sample moves when sample_valid && sample_ready are both high
// on a rising clk edge; a result moves when result_valid && result_ready are
// both high. result_valid and the result words stay stable until that edge.
interface frame_energy_acc_if
    import frame_energy_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int ACC_WIDTH = acc_width(WIDTH, DEPTH)
);
    localparam int SUM_W = WIDTH + $clog2(DEPTH);

    logic                    buffer_ready;
    logic signed [WIDTH-1:0] sample_data;
    logic                    sample_valid;
    logic                    sample_ready;
    logic [ACC_WIDTH-1:0]    result_energy;
    logic [WIDTH-1:0]        result_peak;
    logic                    result_valid;
    logic                    result_ready;
    logic                    frame_overrun;
    logic                    busy;
    fe_state_e               state_dbg;
`ifdef FRAME_ENERGY_SUM_EN
    logic signed [SUM_W-1:0] result_sum;
`endif

    // Block side: consumes samples, produces results.
    modport slave (
        input  buffer_ready,
        input  sample_data,
        input  sample_valid,
        output sample_ready,
        output result_energy,
        output result_peak,
        output result_valid,
        input  result_ready,
        output frame_overrun,
        output busy,
        output state_dbg
`ifdef FRAME_ENERGY_SUM_EN
        , output result_sum
`endif
    );

    // Environment side: RAM controller feeding samples, host taking results.
    modport master (
        output buffer_ready,
        output sample_data,
        output sample_valid,
        input  sample_ready,
        input  result_energy,
        input  result_peak,
        input  result_valid,
        output result_ready,
        input  frame_overrun,
        input  busy,
        input  state_dbg
`ifdef FRAME_ENERGY_SUM_EN
        , input result_sum
`endif
    );

endinterface

// File: rtl/abs_square_stage.sv
// Two-stage magnitude/square pipeline for the frame energy accumulator.
// Stage1 registers |x| (and the raw sample when FRAME_ENERGY_SUM_EN is
// defined); stage2 registers |x|^2 as an unsigned 2*WIDTH-bit value.
module abs_square_stage #(
    parameter int WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [WIDTH-1:0] x,
    input  logic                    valid,
    output logic [WIDTH-1:0]        abs,
    output logic                    abs_valid,
    output logic [2*WIDTH-1:0]      sq,
    output logic                    sq_valid
`ifdef FRAME_ENERGY_SUM_EN
    , output logic signed [WIDTH-1:0] x_q
`endif
);

    logic [WIDTH-1:0]   abs_c;
    logic [2*WIDTH-1:0] abs_ext;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the
    // correct magnitude once read as unsigned, so no saturation is needed.
    always_comb begin
        abs_c   = x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
        abs_ext = {{WIDTH{1'b0}}, abs};
    end

    // Stage1: magnitude of the accepted sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            abs       <= '0;
            abs_valid <= 1'b0;
        end else begin
            abs       <= valid ? abs_c : '0;
            abs_valid <= valid;
        end
    end

`ifdef FRAME_ENERGY_SUM_EN
    // Stage1: raw signed sample for the DC sum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0;
        end else begin
            x_q <= valid ? x : '0;
        end
    end
`endif

    // Stage2: square of the stage1 magnitude.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sq       <= '0;
            sq_valid <= 1'b0;
        end else begin
            sq       <= abs_valid ? abs_ext * abs_ext : '0;
            sq_valid <= abs_valid;
        end
    end

endmodule

// File: rtl/frame_energy_acc.sv
// Frame energy accumulator: drains one DEPTH-sample frame per buffer-ready
// pulse, sums x^2 and tracks max |x|, then offers the pair as one result.
// Optional feature macro: FRAME_ENERGY_SUM_EN adds the signed frame sum.
module frame_energy_acc
    import frame_energy_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int ACC_WIDTH = acc_width(WIDTH, DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    frame_energy_acc_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    fe_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] energy_acc;
    logic [ACC_WIDTH-1:0] energy_next;
    logic [WIDTH-1:0]     peak_acc;
    logic [ACC_WIDTH-1:0] res_energy;
    logic [WIDTH-1:0]     res_peak;
    logic                 res_valid;
    logic                 overrun;
    logic                 accept;

    logic [WIDTH-1:0]     abs_q;
    logic                 abs_valid;
    logic [2*WIDTH-1:0]   sq;
    logic                 sq_valid;

`ifdef FRAME_ENERGY_SUM_EN
    localparam int SUM_W = WIDTH + $clog2(DEPTH);
    logic signed [WIDTH-1:0] x_q;
    logic signed [SUM_W-1:0] sum_acc;
    logic signed [SUM_W-1:0] res_sum;
`endif

    // Accepted samples enter the pipeline; the energy total includes any
    // square landing this cycle so DRAIN can latch without waiting for it.
    always_comb begin
        accept      = bus.sample_valid && (state == ACCUM);
        energy_next = energy_acc + (sq_valid ? ACC_WIDTH'(sq) : '0);
    end

    abs_square_stage #(
        .WIDTH (WIDTH)
    ) u_abs_square (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .x         (bus.sample_data),
        .valid     (accept),
        .abs       (abs_q),
        .abs_valid (abs_valid),
        .sq        (sq),
        .sq_valid  (sq_valid)
`ifdef FRAME_ENERGY_SUM_EN
        , .x_q     (x_q)
`endif
    );

    // FSM with accumulators and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            energy_acc <= '0;
            peak_acc   <= '0;
            res_energy <= '0;
            res_peak   <= '0;
            res_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun    <= bus.buffer_ready && (state != IDLE);
            energy_acc <= energy_next;
            if (abs_valid && (abs_q > peak_acc)) begin
                peak_acc <= abs_q;
            end
            case (state)
                IDLE: begin
                    if (bus.buffer_ready) begin
                        energy_acc <= '0;
                        peak_acc   <= '0;
                        cnt        <= '0;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage1 empty means peak is final and the last square is
                    // either in energy_acc already or arriving now.
                    if (!abs_valid) begin
                        res_energy <= energy_next;
                        res_peak   <= peak_acc;
                        res_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (bus.result_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_ENERGY_SUM_EN
    // Signed frame sum, accumulated from stage1 and latched with the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_acc <= '0;
            res_sum <= '0;
        end else begin
            if (state == IDLE && bus.buffer_ready) begin
                sum_acc <= '0;
            end else if (abs_valid) begin
                sum_acc <= sum_acc + SUM_W'(x_q);
            end
            if (state == DRAIN && !abs_valid) begin
                res_sum <= sum_acc;
            end
        end
    end

    assign bus.result_sum = res_sum;
`endif

    assign bus.sample_ready  = (state == ACCUM);
    assign bus.busy          = (state != IDLE);
    assign bus.result_energy = res_energy;
    assign bus.result_peak   = res_peak;
    assign bus.result_valid  = res_valid;
    assign bus.frame_overrun = overrun;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_frame_energy_acc.sv
// Bench for frame_energy_acc (WIDTH=16, DEPTH=4). Sum checks are active only
// when FRAME_ENERGY_SUM_EN is defined.
module tb_frame_energy_acc;
    import frame_energy_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int ACC_W = 36;
    localparam int SUM_W = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;

    frame_energy_acc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_WIDTH(ACC_W)) bus ();

    frame_energy_acc #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ACC_WIDTH (ACC_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [ACC_W-1:0]        exp_energy_q[$];
    logic [WIDTH-1:0]        exp_peak_q[$];
    logic signed [SUM_W-1:0] exp_sum_q[$];

    logic signed [WIDTH-1:0] frame_buf[DEPTH];

    int  cyc        = 0;
    int  last_acc   = 0;
    int  n_results  = 0;
    int  ov_cnt     = 0;
    bit  prev_valid = 1'b0;
    bit  chk_stall  = 1'b0;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            cyc++;
            if (bus.sample_valid && bus.sample_ready) last_acc = cyc;
            if (bus.frame_overrun) ov_cnt++;
            if (bus.result_valid && !prev_valid) check_eq("latency", 64'(cyc - last_acc), 64'd3);
            if (chk_stall && bus.result_valid && !bus.result_ready && exp_energy_q.size() > 0) begin
                check_eq("stall_energy", 64'(bus.result_energy), 64'(exp_energy_q[0]));
                check_eq("stall_peak", 64'(bus.result_peak), 64'(exp_peak_q[0]));
            end
            if (bus.result_valid && bus.result_ready) begin
                if (exp_energy_q.size() == 0) begin
                    check_eq("sb_underflow", 64'd1, 64'd0);
                end else begin
                    check_eq("energy", 64'(bus.result_energy), 64'(exp_energy_q.pop_front()));
                    check_eq("peak", 64'(bus.result_peak), 64'(exp_peak_q.pop_front()));
`ifdef FRAME_ENERGY_SUM_EN
                    check_eq("sum", 64'(bus.result_sum), 64'(exp_sum_q.pop_front()));
`else
                    void'(exp_sum_q.pop_front());
`endif
                end
                n_results++;
            end
            prev_valid = bus.result_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers are entered and left at posedge+1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_buffer();
        bus.buffer_ready = 1'b1;
        step();
        bus.buffer_ready = 1'b0;
    endtask

    // Model the frame in frame_buf, queue the expected result, then pulse.
    task automatic start_frame();
        longint e = 0;
        int p = 0;
        int s = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int v = int'(frame_buf[i]);
            int a = (v < 0) ? -v : v;
            e += longint'(v) * longint'(v);
            if (a > p) p = a;
            s += v;
        end
        exp_energy_q.push_back(ACC_W'(e));
        exp_peak_q.push_back(WIDTH'(p));
        exp_sum_q.push_back(SUM_W'(s));
        pulse_buffer();
    endtask

    task automatic send_samples(input int first, input int last, input int max_gap);
        for (int i = first; i <= last; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bit done = 1'b0;
            int budget = 0;
            for (int g = 0; g < gap; g++) begin
                bus.sample_valid = 1'b0;
                bus.sample_data  = WIDTH'($urandom);
                step();
            end
            bus.sample_data  = frame_buf[i];
            bus.sample_valid = 1'b1;
            while (!done && budget < 50) begin
                @(negedge clk);
                done = bus.sample_ready;
                step();
                budget++;
            end
            bus.sample_valid = 1'b0;
            if (!done) check_eq("accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic wait_valid();
        int budget = 0;
        while (!bus.result_valid && budget < 50) begin
            step();
            budget++;
        end
        if (!bus.result_valid) check_eq("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_result();
        int target = n_results + 1;
        int budget = 0;
        while (n_results < target && budget < 50) begin
            step();
            budget++;
        end
        if (n_results < target) check_eq("result_timeout", 64'd0, 64'd1);
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        frame_buf[0] = WIDTH'(a);
        frame_buf[1] = WIDTH'(b);
        frame_buf[2] = WIDTH'(c);
        frame_buf[3] = WIDTH'(d);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(bus.result_valid), 64'd0);
        check_eq({tag, "_ready"}, 64'(bus.sample_ready), 64'd0);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_ovr"}, 64'(bus.frame_overrun), 64'd0);
        check_eq({tag, "_energy"}, 64'(bus.result_energy), 64'd0);
        check_eq({tag, "_peak"}, 64'(bus.result_peak), 64'd0);
        check_eq({tag, "_state"}, 64'(bus.state_dbg), 64'(IDLE));
`ifdef FRAME_ENERGY_SUM_EN
        check_eq({tag, "_sum"}, 64'(bus.result_sum), 64'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ov0;
        bus.buffer_ready = 1'b0;
        bus.sample_data  = '0;
        bus.sample_valid = 1'b0;
        bus.result_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("reset");

        // 1: basic frame, ready always high
        load(1, -2, 3, -4);
        start_frame();
        send_samples(0, 3, 0);
        wait_result();

        // 2: most negative sample
        load(-32768, 0, 0, 0);
        start_frame();
        send_samples(0, 3, 0);
        wait_result();

        // 3: random valid gaps, result held off for 10 cycles
        load(1, -2, 3, -4);
        bus.result_ready = 1'b0;
        start_frame();
        send_samples(0, 3, 3);
        wait_valid();
        chk_stall = 1'b1;
        repeat (10) step();
        chk_stall = 1'b0;
        bus.result_ready = 1'b1;
        wait_result();

        // 4: overrun in ACCUM and in OUT
        ov0 = ov_cnt;
        load(7, -9, 100, -3);
        bus.result_ready = 1'b0;
        start_frame();
        send_samples(0, 1, 0);
        pulse_buffer();
        send_samples(2, 3, 0);
        wait_valid();
        pulse_buffer();
        repeat (2) step();
        bus.result_ready = 1'b1;
        wait_result();
        step();
        check_eq("overrun_cnt", 64'(ov_cnt - ov0), 64'd2);
        check_eq("overrun_idle", 64'(bus.busy), 64'd0);

        // 5: reset mid-frame, then a clean frame
        load(20, 30, 0, 0);
        pulse_buffer();
        send_samples(0, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_zero("midreset");
        load(5, 5, 5, 5);
        start_frame();
        send_samples(0, 3, 0);
        wait_result();

        // 6: back-to-back frames with result_ready already high
        ov0 = ov_cnt;
        load(-100, 50, 25, -12);
        start_frame();
        send_samples(0, 3, 0);
        wait_result();
        check_eq("b2b_busy_gap", 64'(bus.busy), 64'd0);
        load(32767, -32767, 1, -1);
        start_frame();
        send_samples(0, 3, 1);
        wait_result();
        step();
        check_eq("b2b_overrun", 64'(ov_cnt - ov0), 64'd0);

        // sample_valid outside ACCUM must not start or disturb anything
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'sd77;
        repeat (3) step();
        bus.sample_valid = 1'b0;
        check_eq("idle_valid_ready", 64'(bus.sample_ready), 64'd0);
        check_eq("idle_valid_busy", 64'(bus.busy), 64'd0);

        check_eq("sb_leftover", 64'(exp_energy_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
